// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and parity helper
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int OVERSAMPLE = 16;

    // One encoding shared by the rx and tx FSMs; PARITY is skipped when disabled.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Parity bit on the line for a given XOR-reduced payload.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick and restartable bit strobe
module uart_baud_tick #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bit_clr,
    output logic o_rx_tick,
    output logic o_bit_stb
);
    import uart_pkg::*;

    localparam int DIV_RAW    = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BIT_CYCLES = DIV * OVERSAMPLE;
    localparam int DW         = $clog2(BIT_CYCLES + 1);

    logic [DW-1:0] r_tick_cnt;
    logic [DW-1:0] r_bit_cnt;
    logic          w_tick_wrap;
    logic          w_bit_wrap;

    assign w_tick_wrap = (r_tick_cnt == DW'(DIV - 1));
    assign w_bit_wrap  = (r_bit_cnt == DW'(BIT_CYCLES - 1));
    assign o_rx_tick   = w_tick_wrap;
    assign o_bit_stb   = w_bit_wrap && !i_bit_clr;

    // Oversample divider, never restarted so rx start detection has a fixed grid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + DW'(1);
        end
    end

    // Bit-period counter, realigned to each accepted tx frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
        end else if (i_bit_clr || w_bit_wrap) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parametrised full-duplex UART with 16x oversampled receiver
module uart_param #(
    parameter int CLOCK_RATE         = 100000000,
    parameter int BAUD_RATE          = 9600,
    parameter int DATA_BITS          = 8,
    parameter int PARITY             = 0,
    parameter int STOP_BITS          = 1,
    parameter int RX_OVERSAMPLE_RATE = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rxEn,
    input  logic                 rx,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParityErr,
    output logic [DATA_BITS-1:0] out,
    input  logic                 txEn,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] in,
    output logic                 txBusy,
    output logic                 txDone,
    output logic                 tx
);
    import uart_pkg::*;

    localparam logic [3:0] RX_MID  = 4'(RX_OVERSAMPLE_RATE / 2 - 1);
    localparam logic [3:0] RX_LAST = 4'(RX_OVERSAMPLE_RATE - 1);

    logic w_rx_tick;
    logic w_bit_stb;

    uart_state_t          r_tx_state, w_tx_next;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic [3:0]           r_tx_cnt;
    logic                 r_tx_done;
    logic                 w_tx_accept, w_tx_end, w_tx_line;

    uart_state_t          r_rx_state, w_rx_next;
    logic                 r_rx_s1, r_rx_s2;
    logic [3:0]           r_rx_tick, r_rx_cnt;
    logic [DATA_BITS-1:0] r_rx_shift, r_out;
    logic                 r_rx_par, r_rx_done, r_rx_err, r_rx_perr;
    logic                 w_rx_go, w_rx_sample, w_rx_start_ok, w_rx_finish;

    uart_baud_tick #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE)
    ) u_baud (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_bit_clr (w_tx_accept),
        .o_rx_tick (w_rx_tick),
        .o_bit_stb (w_bit_stb)
    );

    assign tx          = w_tx_line;
    assign txBusy      = (r_tx_state != ST_IDLE);
    assign txDone      = r_tx_done;
    assign rxBusy      = rxEn && (r_rx_state != ST_IDLE);
    assign rxDone      = r_rx_done;
    assign rxErr       = r_rx_err;
    assign rxParityErr = r_rx_perr;
    assign out         = r_out;

    // Tx state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_tx_state <= ST_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    // Tx next state and line level; each bit ends on the bit strobe.
    always_comb begin
        w_tx_next   = r_tx_state;
        w_tx_accept = 1'b0;
        w_tx_end    = 1'b0;
        w_tx_line   = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                if (txStart && txEn) begin
                    w_tx_next   = ST_START;
                    w_tx_accept = 1'b1;
                end
            end
            ST_START: begin
                w_tx_line = 1'b0;
                if (w_bit_stb) w_tx_next = ST_DATA;
            end
            ST_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_bit_stb && r_tx_cnt == 4'(DATA_BITS - 1))
                    w_tx_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                w_tx_line = r_tx_par;
                if (w_bit_stb) w_tx_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_stb && r_tx_cnt == 4'(STOP_BITS - 1)) begin
                    w_tx_next = ST_IDLE;
                    w_tx_end  = 1'b1;
                end
            end
            default: w_tx_next = ST_IDLE;
        endcase
    end

    // Tx datapath: latch word on accept, shift per data bit, count bits per state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= w_tx_end;
            if (w_tx_accept) begin
                r_tx_shift <= in;
                r_tx_par   <= parity_bit(^in, PARITY);
                r_tx_cnt   <= '0;
            end else if (w_bit_stb && r_tx_state != ST_IDLE) begin
                r_tx_cnt <= (w_tx_next != r_tx_state) ? 4'd0 : r_tx_cnt + 4'd1;
                if (r_tx_state == ST_DATA) r_tx_shift <= r_tx_shift >> 1;
            end
        end
    end

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // Rx state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_rx_state <= ST_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    // Rx next state: mid-bit sampling at tick 8 of start, then every 16 ticks.
    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_go       = 1'b0;
        w_rx_start_ok = 1'b0;
        w_rx_finish   = 1'b0;
        w_rx_sample   = w_rx_tick && (r_rx_state != ST_IDLE) &&
                        (r_rx_tick == ((r_rx_state == ST_START) ? RX_MID : RX_LAST));
        case (r_rx_state)
            ST_IDLE: begin
                if (w_rx_tick && !r_rx_s2) begin
                    w_rx_next = ST_START;
                    w_rx_go   = 1'b1;
                end
            end
            ST_START: begin
                if (w_rx_sample) begin
                    if (r_rx_s2) begin
                        w_rx_next = ST_IDLE;
                    end else begin
                        w_rx_next     = ST_DATA;
                        w_rx_start_ok = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_rx_sample && r_rx_cnt == 4'(DATA_BITS - 1))
                    w_rx_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_rx_sample) w_rx_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_rx_sample) begin
                    w_rx_next   = ST_IDLE;
                    w_rx_finish = 1'b1;
                end
            end
            default: w_rx_next = ST_IDLE;
        endcase
        if (!rxEn) begin
            w_rx_next     = ST_IDLE;
            w_rx_go       = 1'b0;
            w_rx_start_ok = 1'b0;
            w_rx_finish   = 1'b0;
        end
    end

    // Rx datapath: tick/bit counters, shift-in LSB first, result and sticky flags.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rx_tick  <= '0;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_out      <= '0;
            r_rx_done  <= 1'b0;
            r_rx_err   <= 1'b0;
            r_rx_perr  <= 1'b0;
        end else begin
            r_rx_done <= w_rx_finish;
            if (w_rx_go) begin
                r_rx_tick <= '0;
                r_rx_cnt  <= '0;
            end else if (w_rx_tick && r_rx_state != ST_IDLE) begin
                r_rx_tick <= w_rx_sample ? 4'd0 : r_rx_tick + 4'd1;
            end
            if (w_rx_sample) begin
                r_rx_cnt <= (w_rx_next != r_rx_state) ? 4'd0 : r_rx_cnt + 4'd1;
                if (r_rx_state == ST_DATA)   r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                if (r_rx_state == ST_PARITY) r_rx_par   <= r_rx_s2;
            end
            if (w_rx_start_ok) begin
                r_rx_err  <= 1'b0;
                r_rx_perr <= 1'b0;
            end
            if (w_rx_finish) begin
                r_out     <= r_rx_shift;
                r_rx_err  <= !r_rx_s2;
                r_rx_perr <= (PARITY != PARITY_NONE) &&
                             (r_rx_par != parity_bit(^r_rx_shift, PARITY));
            end
        end
    end

endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - scoreboard bench for uart_param in 8N1, 7E2 and 8O1 builds
module tb_uart_param;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 10000;
    localparam int BITC   = 160;

    typedef struct {
        logic [8:0] data;
        logic       err;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rstN;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t e_a, e_b, e_c;

    // instance a: 8N1, loopback or bench-driven rx
    logic       rxEn_a, rx_a, rxBusy_a, rxDone_a, rxErr_a, rxParityErr_a;
    logic [7:0] out_a, in_a;
    logic       txEn_a, txStart_a, txBusy_a, txDone_a, tx_a;
    logic       a_loop, rx_drv_a;
    // instance b: 7E2 loopback
    logic       rxEn_b, rxBusy_b, rxDone_b, rxErr_b, rxParityErr_b;
    logic [6:0] out_b, in_b;
    logic       txEn_b, txStart_b, txBusy_b, txDone_b, tx_b;
    // instance c: 8O1, bench-driven rx
    logic       rxEn_c, rx_drv_c, rxBusy_c, rxDone_c, rxErr_c, rxParityErr_c;
    logic [7:0] out_c, in_c;
    logic       txEn_c, txStart_c, txBusy_c, txDone_c, tx_c;

    logic sel_b;
    logic mon_tx, mon_done, mon_busy;

    assign rx_a     = a_loop ? tx_a : rx_drv_a;
    assign mon_tx   = sel_b ? tx_b     : tx_a;
    assign mon_done = sel_b ? txDone_b : txDone_a;
    assign mon_busy = sel_b ? txBusy_b : txBusy_a;

    always #5 clk = ~clk;

    uart_param #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .RX_OVERSAMPLE_RATE(16)) u_a (
        .clk(clk), .rstN(rstN), .rxEn(rxEn_a), .rx(rx_a), .rxBusy(rxBusy_a),
        .rxDone(rxDone_a), .rxErr(rxErr_a), .rxParityErr(rxParityErr_a), .out(out_a),
        .txEn(txEn_a), .txStart(txStart_a), .in(in_a), .txBusy(txBusy_a),
        .txDone(txDone_a), .tx(tx_a));

    uart_param #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .RX_OVERSAMPLE_RATE(16)) u_b (
        .clk(clk), .rstN(rstN), .rxEn(rxEn_b), .rx(tx_b), .rxBusy(rxBusy_b),
        .rxDone(rxDone_b), .rxErr(rxErr_b), .rxParityErr(rxParityErr_b), .out(out_b),
        .txEn(txEn_b), .txStart(txStart_b), .in(in_b), .txBusy(txBusy_b),
        .txDone(txDone_b), .tx(tx_b));

    uart_param #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .RX_OVERSAMPLE_RATE(16)) u_c (
        .clk(clk), .rstN(rstN), .rxEn(rxEn_c), .rx(rx_drv_c), .rxBusy(rxBusy_c),
        .rxDone(rxDone_c), .rxErr(rxErr_c), .rxParityErr(rxParityErr_c), .out(out_c),
        .txEn(txEn_c), .txStart(txStart_c), .in(in_c), .txBusy(txBusy_c),
        .txDone(txDone_c), .tx(tx_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [8:0] d, input logic err, input logic perr);
        exp_t e;
        e.data = d;
        e.err  = err;
        e.perr = perr;
        return e;
    endfunction

    // Line level of bit k of a frame (single stop bit modelled; later bits idle high).
    function automatic logic frame_bit(input logic [8:0] d, input int nbits, input int par,
                                       input int k, input logic flip_par, input logic stop_low);
        logic [8:0] m;
        logic [8:0] sh;
        logic       p;
        m = (9'd1 << nbits) - 9'd1;
        p = ^(d & m);
        if (par == 2) p = ~p;
        if (k == 0) return 1'b0;
        if (k <= nbits) begin
            sh = d >> (k - 1);
            return sh[0];
        end
        if (par != 0 && k == nbits + 1) return p ^ flip_par;
        if (k == nbits + 1 + ((par != 0) ? 1 : 0)) return ~stop_low;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rstN && rxDone_a) begin
            if (q_a.size() == 0) check("a_spurious_rxdone", 1, 0);
            else begin
                e_a = q_a.pop_front();
                check("a_out", 32'(out_a), 32'(e_a.data));
                check("a_rxerr", 32'(rxErr_a), 32'(e_a.err));
                check("a_rxperr", 32'(rxParityErr_a), 32'(e_a.perr));
            end
        end
    end

    always @(negedge clk) begin
        if (rstN && rxDone_b) begin
            if (q_b.size() == 0) check("b_spurious_rxdone", 1, 0);
            else begin
                e_b = q_b.pop_front();
                check("b_out", 32'(out_b), 32'(e_b.data));
                check("b_rxerr", 32'(rxErr_b), 32'(e_b.err));
                check("b_rxperr", 32'(rxParityErr_b), 32'(e_b.perr));
            end
        end
    end

    always @(negedge clk) begin
        if (rstN && rxDone_c) begin
            if (q_c.size() == 0) check("c_spurious_rxdone", 1, 0);
            else begin
                e_c = q_c.pop_front();
                check("c_out", 32'(out_c), 32'(e_c.data));
                check("c_rxerr", 32'(rxErr_c), 32'(e_c.err));
                check("c_rxperr", 32'(rxParityErr_c), 32'(e_c.perr));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start a tx frame on a or b and check every bit mid-period and the txDone time.
    task automatic tx_frame(input logic use_b, input logic [8:0] data, input int nbits,
                            input int par, input int nstop, input logic poke);
        int    nb;
        int    done_cyc;
        string p;
        nb = 1 + nbits + ((par != 0) ? 1 : 0) + nstop;
        p  = use_b ? "b" : "a";
        sel_b = use_b;
        done_cyc = -1;
        if (use_b) begin in_b = 7'(data); txStart_b = 1'b1; end
        else       begin in_a = 8'(data); txStart_a = 1'b1; end
        tick(1);
        txStart_a = 1'b0;
        txStart_b = 1'b0;
        check($sformatf("%s_tx_fall", p), 32'(mon_tx), 0);
        check($sformatf("%s_txbusy_rise", p), 32'(mon_busy), 1);
        for (int cyc = 1; cyc <= nb * BITC + 50; cyc++) begin
            tick(1);
            if (poke && cyc == 300) begin in_a = 8'hFF; txStart_a = 1'b1; end
            if (poke && cyc == 301) txStart_a = 1'b0;
            if (cyc % BITC == BITC / 2 && cyc / BITC < nb)
                check($sformatf("%s_bit%0d", p, cyc / BITC), 32'(mon_tx),
                      32'(frame_bit(data, nbits, par, cyc / BITC, 1'b0, 1'b0)));
            if (mon_done) begin
                done_cyc = cyc;
                break;
            end
        end
        check($sformatf("%s_txdone_time", p), 32'(done_cyc), 32'(nb * BITC));
        check($sformatf("%s_txbusy_fall", p), 32'(mon_busy), 0);
    endtask

    task automatic set_line(input logic use_c, input logic b);
        if (use_c) rx_drv_c = b;
        else       rx_drv_a = b;
    endtask

    // Drive one frame onto the rx pin of a or c, followed by one idle bit.
    task automatic rx_frame(input logic use_c, input logic [8:0] data, input int nbits,
                            input int par, input logic flip_par, input logic stop_low);
        int nb;
        nb = 1 + nbits + ((par != 0) ? 1 : 0) + 1;
        for (int k = 0; k < nb; k++) begin
            set_line(use_c, frame_bit(data, nbits, par, k, flip_par, stop_low));
            tick(BITC);
        end
        set_line(use_c, 1'b1);
        tick(BITC);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) break;
            tick(1);
        end
        check(tag, 32'(q_a.size() + q_b.size() + q_c.size()), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic bad;
        int   n;
        rstN = 1'b0;
        rxEn_a = 1'b1; rxEn_b = 1'b1; rxEn_c = 1'b1;
        txEn_a = 1'b1; txEn_b = 1'b1; txEn_c = 1'b1;
        txStart_a = 1'b0; txStart_b = 1'b0; txStart_c = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        a_loop = 1'b1; rx_drv_a = 1'b1; rx_drv_c = 1'b1; sel_b = 1'b0;
        tick(5);
        check("rst_tx", 32'(tx_a), 1);
        check("rst_txbusy", 32'(txBusy_a), 0);
        check("rst_txdone", 32'(txDone_a), 0);
        check("rst_rxbusy", 32'(rxBusy_a), 0);
        check("rst_rxdone", 32'(rxDone_a), 0);
        check("rst_rxerr", 32'(rxErr_a), 0);
        check("rst_rxperr", 32'(rxParityErr_c), 0);
        check("rst_out", 32'(out_a), 0);
        rstN = 1'b1;
        tick(50);

        // 8N1 loopback
        q_a.push_back(mk(9'h0A5, 1'b0, 1'b0));
        tx_frame(1'b0, 9'h0A5, 8, 0, 1, 1'b0);
        wait_drain("a_loop_drain");
        tick(20);

        // 7E2 loopback
        q_b.push_back(mk(9'h055, 1'b0, 1'b0));
        tx_frame(1'b1, 9'h055, 7, 1, 2, 1'b0);
        wait_drain("b_loop_drain");
        tick(20);

        // odd parity with corrupted parity bit, then a clean frame clears the flag
        q_c.push_back(mk(9'h00F, 1'b0, 1'b1));
        rx_frame(1'b1, 9'h00F, 8, 2, 1'b1, 1'b0);
        wait_drain("c_perr_drain");
        check("c_perr_hold", 32'(rxParityErr_c), 1);
        q_c.push_back(mk(9'h033, 1'b0, 1'b0));
        fork
            rx_frame(1'b1, 9'h033, 8, 2, 1'b0, 1'b0);
            begin
                tick(250);
                check("c_perr_clear", 32'(rxParityErr_c), 0);
            end
        join
        wait_drain("c_clean_drain");

        // framing error on a
        a_loop = 1'b0;
        q_a.push_back(mk(9'h03C, 1'b1, 1'b0));
        rx_frame(1'b0, 9'h03C, 8, 0, 1'b0, 1'b1);
        wait_drain("a_frame_drain");
        check("a_rxerr_hold", 32'(rxErr_a), 1);
        tick(200);

        // glitch rejection
        seen = 1'b0;
        rx_drv_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (rxBusy_a) seen = 1'b1;
        end
        rx_drv_a = 1'b1;
        check("a_glitch_seen", 32'(seen), 1);
        n = 0;
        while (rxBusy_a && n < 100) begin
            tick(1);
            n++;
        end
        check("a_glitch_idle", 32'(rxBusy_a), 0);
        tick(300);
        a_loop = 1'b1;
        tick(20);

        // txStart while busy has no effect
        q_a.push_back(mk(9'h05A, 1'b0, 1'b0));
        tx_frame(1'b0, 9'h05A, 8, 0, 1, 1'b1);
        wait_drain("a_busy_drain");
        tick(20);

        // txEn low gates acceptance
        txEn_a = 1'b0;
        in_a = 8'h00;
        txStart_a = 1'b1;
        tick(1);
        txStart_a = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!tx_a || txBusy_a) bad = 1'b1;
            tick(1);
        end
        check("a_txen_gate", 32'(bad), 0);
        txEn_a = 1'b1;

        // reset mid-frame
        in_a = 8'h81;
        txStart_a = 1'b1;
        tick(1);
        txStart_a = 1'b0;
        tick(500);
        check("a_midframe_busy", 32'(txBusy_a), 1);
        #1;
        rstN = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_a), 1);
        check("mid_rst_txbusy", 32'(txBusy_a), 0);
        check("mid_rst_rxbusy", 32'(rxBusy_a), 0);
        check("mid_rst_rxerr", 32'(rxErr_a), 0);
        check("mid_rst_out", 32'(out_a), 0);
        check("mid_rst_txdone", 32'(txDone_a), 0);
        tick(5);
        rstN = 1'b1;
        tick(400);
        check("end_queue_a", 32'(q_a.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_param.md
# uart_param

Parametrised single-clock UART: full-duplex transmitter and receiver with configurable data width, parity and stop bits. It is the successor to the fixed 8N1 UART. Clock enables replace derived clocks, so all logic runs on the board clock. It sits between a board pin pair and a byte-level client, such as a command parser or FIFO.

## Interface
- CLOCK_RATE, 100000000: board clock in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- DATA_BITS, 8: payload width, legal 5..9.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: legal values 1 or 2.
- RX_OVERSAMPLE_RATE, 16: fixed; other values are unsupported.

Ports:
- clk  in  1  board clock; the single clock.
- rstN  in  1  asynchronous, active-low reset.
- rxEn  in  1  receiver enable.
- rx  in  1  serial input; asynchronous.
- rxBusy  out  1  frame reception in progress.
- rxDone  out  1  one-cycle pulse; frame received.
- rxErr  out  1  framing error (stop bit sampled low).
- rxParityErr  out  1  parity mismatch on the last frame.
- out  out  DATA_BITS  received word.
- txEn  in  1  transmitter enable.
- txStart  in  1  request to send `in`.
- in  in  DATA_BITS  word to send.
- txBusy  out  1  frame transmission in progress.
- txDone  out  1  one-cycle pulse at end of frame.
- tx  out  1  serial output; idles high.

## Operation
- **Baud ticks**
  - DIV = CLOCK_RATE/(BAUD_RATE*16), integer floor, minimum 1.
  - rxTick: one-cycle enable every DIV clk cycles, free-running from reset.
  - Bit period: 16*DIV clk cycles.
- **Rx synchroniser:** 2-flop synchroniser on `rx`. All rx decisions use the synchronised value.
- **Rx FSM: IDLE, START, DATA, PARITY, STOP.**
  - IDLE: when rxEn=1 and synced rx=0 at an rxTick, go to START and clear the tick count.
  - START: sample at tick 8. If high (glitch), return to IDLE with no outputs. If low, go to DATA.
  - DATA: sample DATA_BITS bits, one every 16 ticks, LSB first.
  - PARITY: state present only if PARITY≠0. Sample 16 ticks after the last data bit.
  - STOP: sample the first stop bit only, even when STOP_BITS=2.
  - At the STOP sample:
    - `out` takes the shifted word.
    - rxDone pulses for 1 clk cycle.
    - rxErr is set if the stop bit is low.
    - rxParityErr is set if parity mismatched.
    - FSM returns to IDLE.
  - rxErr and rxParityErr hold until the next valid start bit, then clear.
  - rxDone still pulses on a framing or parity error.
- **Rx enable:** rxEn=0 forces IDLE immediately and deasserts rxBusy. `out` and the error flags hold.
- **rxBusy:** high in every rx state except IDLE.
- **Tx FSM: IDLE, START, DATA, PARITY, STOP.**
  - Accept: txStart=1, txEn=1 and state IDLE. `in` is latched and the tx bit counter is cleared.
  - txStart while busy, or with txEn=0, is ignored.
  - Frame on the line: start bit 0, then data LSB first, then parity if enabled, then STOP_BITS stop bits of 1.
  - Each bit lasts exactly 16*DIV clk cycles.
  - Parity: even = XOR of the data bits; odd = its inverse.
- **Tx enable:** deasserting txEn mid-frame does not abort the frame; it only gates acceptance.

## Timing
- Reset values: tx=1, txBusy=0, txDone=0, rxBusy=0, rxDone=0, rxErr=0, rxParityErr=0, out=0. Both FSMs reset to IDLE and the tick counters to 0.
- Tx acceptance:
  - tx falls and txBusy rises on the clk edge after the accept cycle.
  - Frame length F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- Tx completion:
  - txBusy falls and txDone pulses for 1 cycle, F*16*DIV cycles after tx fell.
  - A txStart in that same cycle is accepted, so back-to-back frames have no idle gap.
- Rx detection latency: up to 2 sync cycles plus ≤DIV cycles.
- Rx completion:
  - rxDone occurs at about (F_rx-0.5)*16*DIV cycles after the start edge.
  - F_rx counts the bits through the first stop bit.
- Reset mid-frame: outputs go to reset values immediately and tx returns high.

## Structure
- Shared package `uart_pkg`:
  - PARITY_NONE/EVEN/ODD constants.
  - rx and tx state encodings.
  - OVERSAMPLE=16 constant.
- Sub-module `uart_baud_tick`:
  - Parameters CLOCK_RATE and BAUD_RATE.
  - Outputs the free-running rxTick.
  - Provides a restartable bit-period strobe for tx, with a clear input.
- Rx and tx FSMs live in the top module, or in optional `uart_param_rx`/`uart_param_tx` leaves.

## Test plan
All scenarios use CLOCK_RATE=1600000 and BAUD_RATE=10000 (DIV=10, 160 cycles/bit).
- **8N1 loopback** (tx wired to rx), txStart with in=0xA5:
  - tx line reads 0,1,0,1,0,0,1,0,1,1.
  - txDone at 1600 cycles after tx fell.
  - rxDone with out=0xA5, rxErr=0.
- **DATA_BITS=7, PARITY=even, STOP_BITS=2**, send 0x55:
  - Parity bit = 0; frame is 11 bits, 1760 cycles.
  - Receiver returns 0x55, rxParityErr=0.
- **Odd parity, corrupted parity bit** injected on rx for word 0x0F:
  - rxDone pulses, out=0x0F, rxParityErr=1.
  - Flag clears at the next start bit.
- **Framing error:** drive the stop bit low on word 0x3C:
  - rxDone pulses with rxErr=1.
- **Glitch rejection:** a 40-cycle low pulse on idle rx:
  - No rxDone; rxBusy returns low within 100 cycles.
- **Reset and ignored requests:**
  - txStart while busy: no effect on the frame.
  - rstN low mid-frame: tx=1 and all flags 0 in the same cycle.
  - txEn=0 with txStart: no transmission.
